// File: rtl/cdc_pkg.sv
// cdc_pkg: counter sizing and parameter legality helpers shared by the CDC filter
package cdc_pkg;
  function automatic int cnt_width(input int filter_cycles);
    return ($clog2(filter_cycles + 1) < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction
  function automatic bit params_ok(input int channels, input int levels, input int filter_cycles);
    return channels >= 1 && levels >= 2 && filter_cycles >= 1;
  endfunction
endpackage

// File: rtl/cdc_sync_chain_rst.sv
// cdc_sync_chain_rst: multi-flop synchroniser with asynchronous reset to INIT
module cdc_sync_chain_rst #(
  parameter int WIDTH = 1,
  parameter int LEVELS = 2,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  (* async_reg = "true" *) logic [LEVELS-1:0][WIDTH-1:0] r_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= {LEVELS{INIT}};
    else     r_sync <= {r_sync[LEVELS-2:0], i_d};
  assign o_q = r_sync[LEVELS-1];
endmodule

// File: rtl/cdc_sync_filter.sv
// cdc_sync_filter: per-channel synchroniser followed by a consecutive-sample
// deglitch filter with registered rise/fall/glitch pulses
module cdc_sync_filter
  import cdc_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int LEVELS = 2,
  parameter int FILTER_CYCLES = 1,
  parameter logic [CHANNELS-1:0] INIT = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] signal_in,
  output logic [CHANNELS-1:0] signal_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] glitch
);
  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
  if (!params_ok(CHANNELS, LEVELS, FILTER_CYCLES)) begin : g_bad_params
    $fatal(1, "cdc_sync_filter: illegal CHANNELS/LEVELS/FILTER_CYCLES");
  end
  logic [CHANNELS-1:0] w_s;
  cdc_sync_chain_rst #(.WIDTH(CHANNELS), .LEVELS(LEVELS), .INIT(INIT)) u_chain (
    .clk(clk),
    .rst(rst),
    .i_d(signal_in),
    .o_q(w_s)
  );
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          r_out, r_rise, r_fall, r_glitch;
    logic [CW-1:0] r_cnt;
    // a change is accepted on the FILTER_CYCLES-th consecutive differing sample
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_out    <= INIT[c];
        r_cnt    <= '0;
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_glitch <= 1'b0;
      end else begin
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_glitch <= 1'b0;
        if (w_s[c] == r_out) begin
          r_cnt    <= '0;
          r_glitch <= r_cnt != '0;
        end else if (r_cnt == LAST) begin
          r_out  <= w_s[c];
          r_cnt  <= '0;
          r_rise <= w_s[c];
          r_fall <= ~w_s[c];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    assign signal_out[c] = r_out;
    assign rise[c]       = r_rise;
    assign fall[c]       = r_fall;
    assign glitch[c]     = r_glitch;
  end
endmodule

// File: tb/tb_cdc_sync_filter.sv
// tb_cdc_sync_filter: random and directed checks of two filter configurations
// against a history-window model of the accept/reject rules
module tb_cdc_sync_filter;
  localparam int LA = 2, FA = 3, LB = 3, FB = 1, DEPTH = 4096;
  localparam logic [3:0] INITA = 4'b1000;
  localparam logic       INITB = 1'b0;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] sin_a = INITA;
  logic       sin_b = INITB;
  logic [3:0] out_a, rise_a, fall_a, gl_a;
  logic       out_b, rise_b, fall_b, gl_b;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  cdc_sync_filter #(.CHANNELS(4), .LEVELS(LA), .FILTER_CYCLES(FA), .INIT(INITA)) dut_a (
    .clk(clk), .rst(rst), .signal_in(sin_a), .signal_out(out_a),
    .rise(rise_a), .fall(fall_a), .glitch(gl_a)
  );
  cdc_sync_filter #(.CHANNELS(1), .LEVELS(LB), .FILTER_CYCLES(FB), .INIT(INITB)) dut_b (
    .clk(clk), .rst(rst), .signal_in(sin_b), .signal_out(out_b),
    .rise(rise_b), .fall(fall_b), .glitch(gl_b)
  );
  // model: inputs captured per edge since reset; the synchronised sample seen at
  // edge n is the input of edge n-L, and an output change needs F consecutive
  // differing samples that all lie after the previous change (or reset)
  logic [3:0] hist [2][DEPTH];
  int         n_edge [2];
  int         bnd [2][4];
  logic [3:0] m_out [2], m_rise [2], m_fall [2], m_gl [2];
  function automatic logic sval(input int k, input int l, input int j, input int c, input logic [3:0] init);
    if (j < l) return init[c];
    return (j - l < DEPTH) ? hist[k][j-l][c] : 1'b0;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n_edge[k] = 0;
      m_rise[k] = '0;
      m_fall[k] = '0;
      m_gl[k]   = '0;
      for (int c = 0; c < 4; c++) bnd[k][c] = 0;
    end
    m_out[0] = INITA;
    m_out[1] = {3'b000, INITB};
  endtask
  task automatic model_edge(input int k, input int l, input int f, input int nch,
                            input logic [3:0] init, input logic [3:0] din);
    int n = n_edge[k];
    logic [3:0] po = m_out[k];
    bit flip;
    m_rise[k] = '0;
    m_fall[k] = '0;
    m_gl[k]   = '0;
    if (n < DEPTH) hist[k][n] = din;
    for (int c = 0; c < nch; c++) begin
      flip = (n - f + 1 >= bnd[k][c]);
      for (int j = n - f + 1; j <= n; j++)
        if (flip && sval(k, l, j, c, init) == po[c]) flip = 0;
      if (flip) begin
        m_out[k][c]  = ~po[c];
        m_rise[k][c] = ~po[c];
        m_fall[k][c] = po[c];
        bnd[k][c]    = n + 1;
      end else if (n - 1 >= bnd[k][c] && sval(k, l, n, c, init) == po[c]
                   && sval(k, l, n - 1, c, init) != po[c]) begin
        m_gl[k][c] = 1'b1;
      end
    end
    n_edge[k] = n + 1;
  endtask
  always @(posedge rst) model_reset();
  always @(posedge clk)
    if (!rst) begin
      model_edge(0, LA, FA, 4, INITA, sin_a);
      model_edge(1, LB, FB, 1, {3'b000, INITB}, {3'b000, sin_b});
    end
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("out_a", out_a, m_out[0]);
    chk("rise_a", rise_a, m_rise[0]);
    chk("fall_a", fall_a, m_fall[0]);
    chk("glitch_a", gl_a, m_gl[0]);
    chk("excl_a", (rise_a & fall_a) | (rise_a & gl_a) | (fall_a & gl_a), 4'b0000);
    chk("out_b", {3'b000, out_b}, m_out[1]);
    chk("rise_b", {3'b000, rise_b}, m_rise[1]);
    chk("fall_b", {3'b000, fall_b}, m_fall[1]);
    chk("glitch_b", {3'b000, gl_b}, m_gl[1]);
  end
  task automatic step();
    @(negedge clk);
    #2;
  endtask
  task automatic lat_a(input int ch, input logic v, output int e);
    e = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_a[ch] === v) begin
        e = i;
        break;
      end
    end
  endtask
  task automatic lat_b(input logic v, output int e);
    e = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_b === v) begin
        e = i;
        break;
      end
    end
  endtask
  initial begin
    int e, pulses, g, r, p;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(|(rise_a | fall_a | gl_a));
    end
    chk("r29_out", out_a, 4'b1000);
    chki("r29_pulses", pulses, 0);
    step();
    sin_a = 4'b1001;
    lat_a(0, 1'b1, e);
    chki("r30_latency", e, 5);
    chk("r30_rise", rise_a, 4'b0001);
    @(negedge clk);
    chk("r30_rise_once", rise_a, 4'b0000);
    step();
    sin_a = 4'b1011;
    g = 0;
    r = 0;
    repeat (2) begin
      @(negedge clk);
      g += int'(gl_a[1]);
      r += int'(rise_a[1]);
    end
    #2 sin_a = 4'b1001;
    repeat (10) begin
      @(negedge clk);
      g += int'(gl_a[1]);
      r += int'(rise_a[1]);
    end
    chki("r31_glitch_count", g, 1);
    chki("r31_rise_count", r, 0);
    chk("r31_out", out_a, 4'b1001);
    step();
    sin_a = 4'b0100;
    lat_a(2, 1'b1, e);
    chki("r32_latency", e, 5);
    chk("r32_rise", rise_a, 4'b0100);
    chk("r32_fall", fall_a, 4'b1001);
    chk("r32_out", out_a, 4'b0100);
    step();
    sin_a = 4'b0101;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("r33_out_in_reset", out_a, 4'b1000);
    repeat (2) step();
    rst = 1'b0;
    lat_a(0, 1'b1, e);
    chki("r33_latency_after_reset", e, 5);
    for (int t = 0; t < 4; t++) begin
      step();
      sin_b = ~sin_b;
      lat_b(sin_b, e);
      chki("r34_latency", e, 4);
      g = 0;
      repeat (6) begin
        @(negedge clk);
        g += int'(gl_b);
      end
      chki("r34_glitch", g, 0);
    end
    for (int i = 0; i < 1500; i++) begin
      step();
      p = ((i / 100) % 2 == 1) ? 40 : 8;
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        rst = 1'b0;
      end
      if ($urandom_range(0, 99) < p) sin_a = sin_a ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 99) < p) sin_a = sin_a ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 99) < p) sin_b = ~sin_b;
    end
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cdc_sync_filter.md
CDC_SYNC_FILTER -- requirements
Module: cdc_sync_filter

Interface
REQ-001 SHALL have parameter CHANNELS, default 1: number of independent single-bit channels, >=1.
REQ-002 SHALL have parameter LEVELS, default 2: synchroniser flop stages per channel, >=2.
REQ-003 SHALL have parameter FILTER_CYCLES, default 1: consecutive differing samples needed to accept a change, >=1.
REQ-004 SHALL have parameter INIT, default '0: CHANNELS-bit reset value of the sync chain and signal_out.
REQ-005 SHALL have port clk  input  1: destination clock, the only clock.
REQ-006 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-007 SHALL have port signal_in  input  CHANNELS: asynchronous inputs, each driven by a source-domain register.
REQ-008 SHALL have port signal_out  output  CHANNELS: synchronised, filtered level.
REQ-009 SHALL have port rise  output  CHANNELS: one-cycle pulse on a 0->1 change of signal_out.
REQ-010 SHALL have port fall  output  CHANNELS: one-cycle pulse on a 1->0 change of signal_out.
REQ-011 SHALL have port glitch  output  CHANNELS: one-cycle pulse when a pending change is rejected.

Function
REQ-012 Each channel SHALL pass through a LEVELS-deep flop chain; s = last stage, valid LEVELS edges after sampling.
REQ-013 Each channel SHALL own a counter cnt of width $clog2(FILTER_CYCLES+1), minimum 1 bit.
REQ-014 Per edge, when s == signal_out: cnt <= 0; glitch <= (cnt != 0).
REQ-015 Per edge, when s != signal_out and cnt == FILTER_CYCLES-1: signal_out <= s; cnt <= 0.
REQ-016 Per edge, when s != signal_out otherwise: cnt <= cnt+1; signal_out held.
REQ-017 rise/fall SHALL be registered and asserted in the same cycle signal_out first shows its new value, for exactly one cycle.
REQ-018 A held input change SHALL appear on signal_out exactly LEVELS+FILTER_CYCLES edges after the first sampling edge.
REQ-019 FILTER_CYCLES=1 SHALL give a pure synchroniser plus one output register; glitch is then never asserted.
REQ-020 cnt SHALL never exceed FILTER_CYCLES-1 (no wrap-around).
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-014..017 in the same cycle.
REQ-022 rise, fall and glitch SHALL be mutually exclusive per channel per cycle.

Reset
REQ-023 rst SHALL asynchronously set every sync stage and signal_out to INIT, cnt to 0, and rise/fall/glitch to 0.
REQ-024 Reset during a pending count SHALL discard it; after release a change needs the full REQ-018 latency.
REQ-025 Reset release SHALL produce no rise/fall/glitch pulse when signal_in equals INIT.

Structure
REQ-026 Shared package cdc_pkg SHALL hold the counter-width helper function and the parameter legality checks.
REQ-027 The sync chain SHALL be the sub-module cdc_sync_chain_rst (WIDTH, LEVELS, INIT, async reset), carrying the async_reg attribute on all stages.
REQ-028 Illegal parameters (LEVELS<2, FILTER_CYCLES<1, CHANNELS<1) SHALL stop elaboration.

Verification (CHANNELS=4, LEVELS=2, FILTER_CYCLES=3, INIT=4'b1000 unless stated)
REQ-029 Hold rst 3 cycles then release, signal_in=4'b1000 -> signal_out=4'b1000, no pulses for 20 cycles.
REQ-030 signal_in[0] 0->1 held -> signal_out[0]=1 exactly 5 edges after first sampling edge; rise[0] high for that one cycle only.
REQ-031 signal_in[1] high for 2 cycles then low -> signal_out[1] stays 0, one glitch[1] pulse, no rise[1].
REQ-032 signal_in[2] 0->1 and signal_in[3] 1->0 on the same edge -> rise[2] and fall[3] in the same cycle; signal_out=4'b0100.
REQ-033 Assert rst when channel 0 cnt=2 -> signal_out[0]=0 immediately; after release a held 1 takes 5 more edges.
REQ-034 LEVELS=3, FILTER_CYCLES=1: toggle signal_in[0] every 10 cycles -> signal_out[0] follows with latency 4, glitch never asserted.
